// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: next-PC select
// encoding and default parameter values.
package pc_sequencer_pkg;

    localparam int DEFAULT_WIDTH        = 16;
    localparam int DEFAULT_DEPTH        = 4;
    localparam int DEFAULT_RESET_VECTOR = 0;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_RET,
        SEL_CALL,
        SEL_JUMP,
        SEL_BRANCH,
        SEL_INC
    } pc_sel_e;

endpackage : pc_sequencer_pkg

// File: rtl/pc_ras.sv
// Return-address stack: LIFO of DEPTH entries with occupancy count.
// Push is ignored while full, pop is ignored while empty; pop wins if both are asserted.
module pc_ras #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               push_data,
    output logic [WIDTH-1:0]               top,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     depth
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    top_idx;
    logic             do_push;
    logic             do_pop;

    assign full    = (depth == DW'(DEPTH));
    assign empty   = (depth == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && !pop && !full;
    assign wr_idx  = AW'(depth);
    assign top_idx = AW'(depth - DW'(1));
    assign top     = mem[top_idx];

    // NOTE: storage has no reset; entries are only read below depth, which is reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            depth <= '0;
        end else if (do_pop) begin
            depth <= depth - DW'(1);
        end else if (do_push) begin
            depth <= depth + DW'(1);
        end
    end

endmodule : pc_ras

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with jump, call/return via a return-address
// stack, conditional relative branch, stall and sticky stack error flags.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int               WIDTH        = DEFAULT_WIDTH,
    parameter int               DEPTH        = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       jump,
    input  logic                       call,
    input  logic                       ret,
    input  logic                       branch,
    input  logic                       cond,
    input  logic [WIDTH-1:0]           target,
    input  logic [WIDTH-1:0]           offset,
    output logic [WIDTH-1:0]           program_counter,
    output logic [$clog2(DEPTH+1)-1:0] stack_depth,
    output logic                       stack_overflow,
    output logic                       stack_underflow
);

    pc_sel_e          sel;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] next_pc;
    logic [WIDTH-1:0] ras_top;
    logic             ras_full;
    logic             ras_empty;
    logic             set_overflow;
    logic             set_underflow;

    assign pc_inc = program_counter + WIDTH'(1);

    // NOTE: every signal gets a default first so this block can never infer a latch.
    always_comb begin
        sel = SEL_INC;
        if (stall) begin
            sel = SEL_HOLD;
        end else if (ret) begin
            // A return from an empty stack falls through to a plain increment.
            sel = ras_empty ? SEL_INC : SEL_RET;
        end else if (call) begin
            sel = SEL_CALL;
        end else if (jump) begin
            sel = SEL_JUMP;
        end else if (branch && cond) begin
            sel = SEL_BRANCH;
        end
    end

    always_comb begin
        next_pc = program_counter;
        unique case (sel)
            SEL_HOLD:   next_pc = program_counter;
            SEL_RET:    next_pc = ras_top;
            SEL_CALL:   next_pc = target;
            SEL_JUMP:   next_pc = target;
            SEL_BRANCH: next_pc = program_counter + offset;
            SEL_INC:    next_pc = pc_inc;
            default:    next_pc = program_counter;
        endcase
    end

    assign set_overflow  = (sel == SEL_CALL) && ras_full;
    assign set_underflow = !stall && ret && ras_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            program_counter <= RESET_VECTOR;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else begin
            program_counter <= next_pc;
            stack_overflow  <= stack_overflow | set_overflow;
            stack_underflow <= stack_underflow | set_underflow;
        end
    end

    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (sel == SEL_CALL),
        .pop       (sel == SEL_RET),
        .push_data (pc_inc),
        .top       (ras_top),
        .full      (ras_full),
        .empty     (ras_empty),
        .depth     (stack_depth)
    );

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: the driver queues the expected state
// after each edge, a monitor pops and compares on the following falling edge.
module tb_pc_sequencer;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam logic [WIDTH-1:0] RV = 16'h0100;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             stall = 1'b0;
    logic             jump = 1'b0;
    logic             call = 1'b0;
    logic             ret = 1'b0;
    logic             branch = 1'b0;
    logic             cond = 1'b0;
    logic [WIDTH-1:0] target = '0;
    logic [WIDTH-1:0] offset = '0;
    logic [WIDTH-1:0] program_counter;
    logic [2:0]       stack_depth;
    logic             stack_overflow;
    logic             stack_underflow;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] pc;
        logic [2:0]       depth;
        logic             ovf;
        logic             unf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   stim_done = 1'b0;

    pc_sequencer #(
        .WIDTH        (WIDTH),
        .DEPTH        (DEPTH),
        .RESET_VECTOR (RV)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .jump            (jump),
        .call            (call),
        .ret             (ret),
        .branch          (branch),
        .cond            (cond),
        .target          (target),
        .offset          (offset),
        .program_counter (program_counter),
        .stack_depth     (stack_depth),
        .stack_overflow  (stack_overflow),
        .stack_underflow (stack_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Control vector: {reset, stall, ret, call, jump, branch, cond}
    task automatic step(input string name, input logic [6:0] ctl,
                        input logic [WIDTH-1:0] tgt, input logic [WIDTH-1:0] off,
                        input logic [WIDTH-1:0] e_pc, input logic [2:0] e_depth,
                        input logic e_ovf, input logic e_unf);
        exp_t e;
        @(negedge clk);
        {reset, stall, ret, call, jump, branch, cond} = ctl;
        target = tgt;
        offset = off;
        @(posedge clk);
        #1;
        e.name  = name;
        e.pc    = e_pc;
        e.depth = e_depth;
        e.ovf   = e_ovf;
        e.unf   = e_unf;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, ".pc"},    32'(program_counter), 32'(e.pc));
            check({e.name, ".depth"}, 32'(stack_depth),     32'(e.depth));
            check({e.name, ".ovf"},   32'(stack_overflow),  32'(e.ovf));
            check({e.name, ".unf"},   32'(stack_underflow), 32'(e.unf));
        end
    end

    localparam logic [6:0] IDLE  = 7'b000_0000;
    localparam logic [6:0] RST   = 7'b100_0000;
    localparam logic [6:0] STL   = 7'b010_0000;
    localparam logic [6:0] RET   = 7'b001_0000;
    localparam logic [6:0] CALL  = 7'b000_1000;
    localparam logic [6:0] JMP   = 7'b000_0100;
    localparam logic [6:0] BR_T  = 7'b000_0011;
    localparam logic [6:0] BR_NT = 7'b000_0010;

    initial begin
        // Reset and free-running increment
        step("reset",   RST,  16'h0000, 16'h0000, 16'h0100, 3'd0, 1'b0, 1'b0);
        step("idle1",   IDLE, 16'h0000, 16'h0000, 16'h0101, 3'd0, 1'b0, 1'b0);
        step("idle2",   IDLE, 16'h0000, 16'h0000, 16'h0102, 3'd0, 1'b0, 1'b0);
        step("idle3",   IDLE, 16'h0000, 16'h0000, 16'h0103, 3'd0, 1'b0, 1'b0);
        // Wrap and branches
        step("jmp_top", JMP,  16'hFFFF, 16'h0000, 16'hFFFF, 3'd0, 1'b0, 1'b0);
        step("wrap",    IDLE, 16'h0000, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0);
        step("jmp_10",  JMP,  16'h0010, 16'h0000, 16'h0010, 3'd0, 1'b0, 1'b0);
        step("br_back", BR_T, 16'h0000, 16'hFFFE, 16'h000E, 3'd0, 1'b0, 1'b0);
        step("br_nt",   BR_NT,16'h0000, 16'h0040, 16'h000F, 3'd0, 1'b0, 1'b0);
        step("jmp_ovr_br", JMP | BR_T, 16'h0030, 16'h0020, 16'h0030, 3'd0, 1'b0, 1'b0);
        // Single call/return
        step("jmp_20",  JMP,  16'h0020, 16'h0000, 16'h0020, 3'd0, 1'b0, 1'b0);
        step("call1",   CALL, 16'h0400, 16'h0000, 16'h0400, 3'd1, 1'b0, 1'b0);
        step("ret1",    RET,  16'h0000, 16'h0000, 16'h0021, 3'd0, 1'b0, 1'b0);
        // Underflow and stall
        step("jmp_5",   JMP,  16'h0005, 16'h0000, 16'h0005, 3'd0, 1'b0, 1'b0);
        step("ret_empty", RET, 16'h0000, 16'h0000, 16'h0006, 3'd0, 1'b0, 1'b1);
        step("stall_jmp", STL | JMP, 16'h1234, 16'h0000, 16'h0006, 3'd0, 1'b0, 1'b1);
        step("stall_call", STL | CALL, 16'h2222, 16'h0000, 16'h0006, 3'd0, 1'b0, 1'b1);
        // Simultaneous call and ret: ret only
        step("jmp_40",  JMP,  16'h0040, 16'h0000, 16'h0040, 3'd0, 1'b0, 1'b1);
        step("call_500", CALL, 16'h0500, 16'h0000, 16'h0500, 3'd1, 1'b0, 1'b1);
        step("call_ret", CALL | RET, 16'h0700, 16'h0000, 16'h0041, 3'd0, 1'b0, 1'b1);
        // Nested calls to overflow, then LIFO returns
        step("jmp_100", JMP,  16'h0100, 16'h0000, 16'h0100, 3'd0, 1'b0, 1'b1);
        step("nest1",   CALL, 16'h1000, 16'h0000, 16'h1000, 3'd1, 1'b0, 1'b1);
        step("nest2",   CALL, 16'h2000, 16'h0000, 16'h2000, 3'd2, 1'b0, 1'b1);
        step("nest3",   CALL, 16'h3000, 16'h0000, 16'h3000, 3'd3, 1'b0, 1'b1);
        step("nest4",   CALL, 16'h4000, 16'h0000, 16'h4000, 3'd4, 1'b0, 1'b1);
        step("nest5_ovf", CALL, 16'h5000, 16'h0000, 16'h5000, 3'd4, 1'b1, 1'b1);
        step("pop4",    RET,  16'h0000, 16'h0000, 16'h3001, 3'd3, 1'b1, 1'b1);
        step("pop3",    RET,  16'h0000, 16'h0000, 16'h2001, 3'd2, 1'b1, 1'b1);
        step("pop2",    RET,  16'h0000, 16'h0000, 16'h1001, 3'd1, 1'b1, 1'b1);
        step("pop1",    RET,  16'h0000, 16'h0000, 16'h0101, 3'd0, 1'b1, 1'b1);
        step("stall_ret", STL | RET, 16'h0000, 16'h0000, 16'h0101, 3'd0, 1'b1, 1'b1);
        // Reset overriding a call at depth 2
        step("c600",    CALL, 16'h0600, 16'h0000, 16'h0600, 3'd1, 1'b1, 1'b1);
        step("c700",    CALL, 16'h0700, 16'h0000, 16'h0700, 3'd2, 1'b1, 1'b1);
        step("rst_call", RST | STL | CALL, 16'h0800, 16'h0000, 16'h0100, 3'd0, 1'b0, 1'b0);
        step("post_rst", IDLE, 16'h0000, 16'h0000, 16'h0101, 3'd0, 1'b0, 1'b0);
        step("post_ret", RET,  16'h0000, 16'h0000, 16'h0102, 3'd0, 1'b0, 1'b1);
        @(negedge clk);
        {reset, stall, ret, call, jump, branch, cond} = IDLE;
        stim_done = 1'b1;
    end

    initial begin
        int budget;
        budget = 0;
        while (!(stim_done && exp_q.size() == 0) && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        #1;
        if (exp_q.size() != 0 || !stim_done) begin
            errors++;
            $display("FAIL timeout: %0d expectations pending", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pc_sequencer
